// File: rtl/elixirchip_es1_spu_op_logic_if.sv
// Sample/result bundle for the ES1 SPU bitwise logic op.
// Handshake: a sample (s_op, s_data0, s_data1, s_clear, s_valid) is taken on every
// clk edge where cke=1; there is no backpressure. s_valid marks a sample that carries a
// result, and s_clear marks a sample that resets the output. m_valid=1 means m_data was
// loaded with a fresh result on the last enabled edge. m_data holds between updates.
interface elixirchip_es1_spu_op_logic_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_CH    = 2
);
  localparam int W = NUM_CH * DATA_BITS;

  logic [2:0]   s_op;
  logic [W-1:0] s_data0;
  logic [W-1:0] s_data1;
  logic         s_clear;
  logic         s_valid;
  logic [W-1:0] m_data;
  logic         m_valid;

  modport master (
    output s_op, s_data0, s_data1, s_clear, s_valid,
    input  m_data, m_valid
  );

  modport slave (
    input  s_op, s_data0, s_data1, s_clear, s_valid,
    output m_data, m_valid
  );
endinterface

// File: rtl/elixirchip_es1_spu_op_logic.sv
// Pipelined multi-lane bitwise logic unit. Control (op/clear/valid) and operands travel
// through LATENCY-1 input stages, then a single output register computes and holds the result.
module elixirchip_es1_spu_op_logic #(
  parameter int  LATENCY         = 2,
  parameter int  DATA_BITS       = 8,
  parameter int  NUM_CH          = 2,
  parameter type data_t          = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA    = '1,
  parameter bit  IMMEDIATE_DATA0 = 1'b0,
  parameter bit  IMMEDIATE_DATA1 = 1'b0,
  parameter      DEVICE          = "RTL",
  parameter      SIMULATION      = "false",
  parameter      DEBUG           = "false"
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cke,
  elixirchip_es1_spu_op_logic_if.slave      bus
);

  localparam int W = NUM_CH * DATA_BITS;
  localparam logic [W-1:0] CLEAR_VEC = {NUM_CH{DATA_BITS'(CLEAR_DATA)}};

  // Elaboration-time parameter sanity checks.
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be >= 1");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("DEVICE must be named");
  end
  if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
    $error("SIMULATION must be \"true\" or \"false\"");
  end
  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("DEBUG must be \"true\" or \"false\"");
  end

  typedef struct packed {
    logic [2:0] op;
    logic       clear;
    logic       valid;
  } ctl_t;

  ctl_t         ctl_in;
  ctl_t         ctl_c;     // control as seen by the compute/output stage
  logic [W-1:0] a_c;
  logic [W-1:0] b_c;
  logic [W-1:0] result;
  logic [W-1:0] m_data_d, m_data_q;
  logic         m_valid_d, m_valid_q;

  assign ctl_in = {bus.s_op, bus.s_clear, bus.s_valid};

  // Control pipeline: flags are reset so nothing in flight survives a reset.
  if (LATENCY <= 1) begin : g_ctl_direct
    assign ctl_c = ctl_in;
  end else begin : g_ctl_pipe
    ctl_t ctl_q [LATENCY-1];
    // Shift the control flags one stage per enabled edge; reset clears every stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LATENCY-1; i++) ctl_q[i] <= '0;
      end else if (cke) begin
        ctl_q[0] <= ctl_in;
        for (int i = 1; i < LATENCY-1; i++) ctl_q[i] <= ctl_q[i-1];
      end
    end
    assign ctl_c = ctl_q[LATENCY-2];
  end

  // Operand A: a constant operand can be read straight at the compute stage.
  if (IMMEDIATE_DATA0 || LATENCY <= 1) begin : g_a_direct
    assign a_c = bus.s_data0;
  end else begin : g_a_pipe
    logic [W-1:0] a_q [LATENCY-1];
    // Operand A delay line; its contents are meaningless without a matching control flag.
    always_ff @(posedge clk) begin
      if (cke) begin
        a_q[0] <= bus.s_data0;
        for (int i = 1; i < LATENCY-1; i++) a_q[i] <= a_q[i-1];
      end
    end
    assign a_c = a_q[LATENCY-2];
  end

  // Operand B: same arrangement as operand A.
  if (IMMEDIATE_DATA1 || LATENCY <= 1) begin : g_b_direct
    assign b_c = bus.s_data1;
  end else begin : g_b_pipe
    logic [W-1:0] b_q [LATENCY-1];
    // Operand B delay line.
    always_ff @(posedge clk) begin
      if (cke) begin
        b_q[0] <= bus.s_data1;
        for (int i = 1; i < LATENCY-1; i++) b_q[i] <= b_q[i-1];
      end
    end
    assign b_c = b_q[LATENCY-2];
  end

  // Bitwise op; being bitwise, it is lane-independent over the whole packed vector.
  always_comb begin
    result = a_c & b_c;
    case (ctl_c.op)
      3'd0: result = a_c & b_c;
      3'd1: result = a_c | b_c;
      3'd2: result = a_c ^ b_c;
      3'd3: result = ~(a_c & b_c);
      3'd4: result = ~(a_c | b_c);
      3'd5: result = ~(a_c ^ b_c);
      3'd6: result = a_c & ~b_c;
      default: result = a_c;
    endcase
  end

  // Output next state: clear beats valid; otherwise data holds and valid drops.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = 1'b0;
    if (ctl_c.clear) begin
      m_data_d = CLEAR_VEC;
    end else if (ctl_c.valid) begin
      m_data_d  = result;
      m_valid_d = 1'b1;
    end
  end

  // Output register; frozen while cke=0, forced to the clear value on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_q  <= CLEAR_VEC;
      m_valid_q <= 1'b0;
    end else if (cke) begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// Bench for elixirchip_es1_spu_op_logic: three configurations share one stimulus stream,
// each with its own expected queue fed at issue time and drained by an output monitor.
module tb_elixirchip_es1_spu_op_logic;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [2:0]  s_op;
  logic [31:0] s_data0;
  logic [31:0] s_data1;
  logic        s_clear;
  logic        s_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_lane(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // ---------------- DUTs + scoreboards ----------------
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int L  = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int NC = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int W  = NC * 8;

    elixirchip_es1_spu_op_logic_if #(.DATA_BITS(8), .NUM_CH(NC)) bus ();

    assign bus.s_op    = s_op;
    assign bus.s_data0 = s_data0[W-1:0];
    assign bus.s_data1 = s_data1[W-1:0];
    assign bus.s_clear = s_clear;
    assign bus.s_valid = s_valid;

    elixirchip_es1_spu_op_logic #(.LATENCY(L), .DATA_BITS(8), .NUM_CH(NC)) dut (
      .clk   (clk),
      .reset (reset),
      .cke   (cke),
      .bus   (bus)
    );

    logic [W:0]   exp_q[$];   // {valid, data}
    logic [W-1:0] mdl_data;
    logic [W:0]   cur;

    // Issue side: every accepted sample yields the output state it will produce.
    always @(posedge clk) begin : issue
      logic v;
      if (reset) begin
        exp_q.delete();
        repeat (L-1) exp_q.push_back({1'b0, {NC{8'hFF}}});
        mdl_data = {NC{8'hFF}};
      end else if (cke) begin
        v = 1'b0;
        if (s_clear) begin
          mdl_data = {NC{8'hFF}};
        end else if (s_valid) begin
          for (int k = 0; k < NC; k++)
            mdl_data[k*8 +: 8] = ref_lane(s_op, s_data0[k*8 +: 8], s_data1[k*8 +: 8]);
          v = 1'b1;
        end
        exp_q.push_back({v, mdl_data});
      end
    end

    // Monitor side: after every edge, pop on enabled edges, otherwise expect a hold.
    always @(posedge clk) begin : monitor
      logic en, rs;
      en = cke;
      rs = reset;
      #1;
      if (rs) begin
        cur = {1'b0, {NC{8'hFF}}};
      end else if (en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb%0d underflow at t=%0t: got empty queue, required an entry", g, $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      n_checks++;
      if ({bus.m_valid, bus.m_data} !== cur) begin
        n_fail++;
        $display("FAIL sb%0d output t=%0t: got v=%b d=%h, required v=%b d=%h",
                 g, $time, bus.m_valid, bus.m_data, cur[W], cur[W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic clr, input logic vld, input logic ce);
    @(negedge clk);
    s_op    = op;
    s_data0 = a;
    s_data1 = b;
    s_clear = clr;
    s_valid = vld;
    cke     = ce;
  endtask

  task automatic idle();
    put(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // Directed check of the 2-lane, latency-2 instance against fixed values.
  task automatic expect_now(input string name, input logic [15:0] d, input logic v);
    n_checks++;
    if (g_cfg[0].bus.m_data !== d || g_cfg[0].bus.m_valid !== v) begin
      n_fail++;
      $display("FAIL %s t=%0t: got v=%b d=%h, required v=%b d=%h",
               name, $time, g_cfg[0].bus.m_valid, g_cfg[0].bus.m_data, v, d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] sweep_tab [8];
    int          en_edges;
    logic        ce, rs;

    sweep_tab = '{16'hA00C, 16'hFA3F, 16'h5A33, 16'h5FF3,
                  16'h05C0, 16'hA5CC, 16'h5030, 16'hF03C};

    reset = 1'b1; cke = 1'b0; s_op = 3'd0;
    s_data0 = 32'h0; s_data1 = 32'h0; s_clear = 1'b0; s_valid = 1'b0;

    // Reset held for 3 clocks with cke low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_now("reset_state", 16'hFFFF, 1'b0);
    reset = 1'b0;
    repeat (3) idle();
    expect_now("post_reset_idle", 16'hFFFF, 1'b0);

    // Op sweep, one op per enabled edge.
    for (int k = 0; k < 10; k++) begin
      if (k < 8) put(k[2:0], 32'h0000_F03C, 32'h0000_AA0F, 1'b0, 1'b1, 1'b1);
      else       idle();
      if (k >= 2) expect_now($sformatf("op_sweep_%0d", k-2), sweep_tab[k-2], 1'b1);
    end

    // Clear beats valid.
    put(3'd1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    idle();
    idle();
    expect_now("clear_priority", 16'hFFFF, 1'b0);
    repeat (3) idle();
    expect_now("clear_hold", 16'hFFFF, 1'b0);

    // Stall for 5 clocks between accepting a sample and its emergence.
    put(3'd0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b1, 1'b1);
    repeat (5) put(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_now("stall_hold", 16'hFFFF, 1'b0);
    idle();
    expect_now("stall_pre_result", 16'hFFFF, 1'b0);
    idle();
    expect_now("stall_result", 16'h0F0F, 1'b1);
    idle();
    expect_now("stall_after", 16'h0F0F, 1'b0);

    // Reset while a valid XOR is in flight.
    put(3'd2, 32'h0000_F03C, 32'h0000_AA0F, 1'b0, 1'b1, 1'b1);
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    expect_now("reset_mid_flight", 16'hFFFF, 1'b0);
    repeat (3) idle();
    expect_now("reset_mid_hold", 16'hFFFF, 1'b0);

    // Random phase: 10000 enabled edges, cke ~90% high, rare resets.
    en_edges = 0;
    while (en_edges < 10000) begin
      ce = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 599) == 0);
      put(3'($urandom_range(0, 7)), $urandom, $urandom,
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ce);
      reset = rs;
      if (ce && !rs) en_edges++;
    end
    reset = 1'b0;
    repeat (5) idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
